// File: rtl/frame_sel_ctrl.sv
// ---------------------------------------------------------------------------
// frame_sel_ctrl
//
// Purpose:
//   Drives the one-hot selects of the frame multiplexer (Buf0 / blank / Buf1)
//   and the raster pixel coordinates used to read the selected buffer.
//   Owns the double-buffer handshake with the frame writer. It accepts
//   "buffer ready" pulses and swaps the displayed buffer only at frame
//   boundaries. It returns a "buffer free" pulse once a buffer stops being
//   displayed.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Reset_n     in   asynchronous active-low reset
//   Enable      in   pixel-clock enable, raster advances only when 1
//   Buf0Ready   in   pulse: Buf0 holds a complete frame
//   Buf1Ready   in   pulse: Buf1 holds a complete frame
//   SelBuf0     out  select Buf0 pixel data
//   SelBlank    out  select blank pixel data
//   SelBuf1     out  select Buf1 pixel data
//   PixAddrX    out  current column, 0..H_TOTAL-1
//   PixAddrY    out  current line, 0..V_TOTAL-1
//   Buf0Free    out  pulse: Buf0 released to the writer
//   Buf1Free    out  pulse: Buf1 released to the writer
//   FrameStart  out  pulse when the raster enters (0,0)
//   Underrun    out  pulse: a frame starts with no buffer available
// ---------------------------------------------------------------------------
module frame_sel_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Enable,
    input  logic          Buf0Ready,
    input  logic          Buf1Ready,
    output logic          SelBuf0,
    output logic          SelBlank,
    output logic          SelBuf1,
    output logic [XW-1:0] PixAddrX,
    output logic [YW-1:0] PixAddrY,
    output logic          Buf0Free,
    output logic          Buf1Free,
    output logic          FrameStart,
    output logic          Underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          full0_q, full0_d;
    logic          full1_q, full1_d;
    logic          sel0_q, sel0_d;
    logic          blank_q, blank_d;
    logic          sel1_q, sel1_d;
    logic          free0_q, free0_d;
    logic          free1_q, free1_d;
    logic          fs_q, fs_d;
    logic          ur_q, ur_d;

    logic          boundary;
    logic          full0_set;
    logic          full1_set;
    logic          active_d;

    // Boundary is the last pixel of the frame on an enabled cycle. A Ready
    // pulse for the buffer on screen is a protocol violation and is dropped.
    // A Ready arriving in the boundary cycle itself already counts.
    always_comb begin
        boundary  = Enable && (x_q == X_LAST) && (y_q == Y_LAST);
        full0_set = full0_q || (Buf0Ready && (state_q != SHOW0));
        full1_set = full1_q || (Buf1Ready && (state_q != SHOW1));
    end

    // State register: raster, FSM, full flags and all registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            sel0_q  <= 1'b0;
            blank_q <= 1'b1;
            sel1_q  <= 1'b0;
            free0_q <= 1'b0;
            free1_q <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            full0_q <= full0_d;
            full1_q <= full1_d;
            sel0_q  <= sel0_d;
            blank_q <= blank_d;
            sel1_q  <= sel1_d;
            free0_q <= free0_d;
            free1_q <= free1_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    // Next-state logic: raster counters, buffer ownership FSM and full flags.
    // The FSM only moves on the boundary, so a buffer swap never tears a frame.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        state_d = state_q;
        full0_d = full0_set;
        full1_d = full1_set;

        if (Enable) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        if (boundary) begin
            case (state_q)
                IDLE: begin
                    if (full0_set) begin
                        state_d = SHOW0;
                    end else if (full1_set) begin
                        state_d = SHOW1;
                    end
                end
                SHOW0: begin
                    if (full1_set) begin
                        state_d = SHOW1;
                        full0_d = 1'b0;
                    end
                end
                SHOW1: begin
                    if (full0_set) begin
                        state_d = SHOW0;
                        full1_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: selects are computed from the next position and state.
    // The registered selects then describe the pixel address shown alongside
    // them. Pulses are registered, so they land on the (0,0) cycle.
    always_comb begin
        active_d = (x_d < X_ACT) && (y_d < Y_ACT);
        sel0_d   = active_d && (state_d == SHOW0);
        sel1_d   = active_d && (state_d == SHOW1);
        blank_d  = !(sel0_d || sel1_d);
        fs_d     = boundary;
        ur_d     = boundary && (state_q == IDLE) && !full0_set && !full1_set;
        free0_d  = boundary && (state_q == SHOW0) && full1_set;
        free1_d  = boundary && (state_q == SHOW1) && full0_set;
    end

    assign SelBuf0    = sel0_q;
    assign SelBlank   = blank_q;
    assign SelBuf1    = sel1_q;
    assign PixAddrX   = x_q;
    assign PixAddrY   = y_q;
    assign Buf0Free   = free0_q;
    assign Buf1Free   = free1_q;
    assign FrameStart = fs_q;
    assign Underrun   = ur_q;

endmodule

// File: tb/tb_frame_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_sel_ctrl
//
// Purpose:
//   Self-checking bench for frame_sel_ctrl on a small 6x4 raster
//   (4x3 active). A behavioural model tracks the raster as a single linear
//   position within the frame. It tracks buffer ownership as "which buffer
//   is shown" plus a pending flag per buffer. Directed table vectors and
//   hand sequences add fixed expectations on top.
//
// Ports:
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_frame_sel_ctrl;

    localparam int H_ACTIVE = 4;
    localparam int H_BLANK  = 2;
    localparam int V_ACTIVE = 3;
    localparam int V_BLANK  = 1;
    localparam int XW       = 3;
    localparam int YW       = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL  = V_ACTIVE + V_BLANK;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    typedef struct packed {
        logic          sel0;
        logic          blank;
        logic          sel1;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          free0;
        logic          free1;
        logic          fs;
        logic          ur;
    } obs_t;

    typedef struct {
        string name;
        bit    en;
        bit    r0;
        bit    r1;
        int    cycles;
        obs_t  exp;
    } tvec_t;

    logic          Clk;
    logic          Reset_n;
    logic          Enable;
    logic          Buf0Ready;
    logic          Buf1Ready;
    logic          SelBuf0;
    logic          SelBlank;
    logic          SelBuf1;
    logic [XW-1:0] PixAddrX;
    logic [YW-1:0] PixAddrY;
    logic          Buf0Free;
    logic          Buf1Free;
    logic          FrameStart;
    logic          Underrun;

    int    nVectors;
    int    nMiscompares;
    string phase;

    // Reference model state: linear raster position, displayed buffer
    // (-1 = none), per-buffer pending flags and the pulses due this cycle.
    int mPos;
    int mDisp;
    bit mPend[2];
    bit mFree[2];
    bit mFs;
    bit mUr;

    tvec_t tbl[$];

    frame_sel_ctrl #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK),
        .XW       (XW),
        .YW       (YW)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .Buf0Ready  (Buf0Ready),
        .Buf1Ready  (Buf1Ready),
        .SelBuf0    (SelBuf0),
        .SelBlank   (SelBlank),
        .SelBuf1    (SelBuf1),
        .PixAddrX   (PixAddrX),
        .PixAddrY   (PixAddrY),
        .Buf0Free   (Buf0Free),
        .Buf1Free   (Buf1Free),
        .FrameStart (FrameStart),
        .Underrun   (Underrun)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic obs_t mkObs(bit s0, bit bl, bit s1, int x, int y,
                                   bit f0, bit f1, bit fs, bit ur);
        obs_t o;
        o.sel0  = s0;
        o.blank = bl;
        o.sel1  = s1;
        o.x     = XW'(x);
        o.y     = YW'(y);
        o.free0 = f0;
        o.free1 = f1;
        o.fs    = fs;
        o.ur    = ur;
        return o;
    endfunction

    function automatic obs_t modelObs();
        int  x;
        int  y;
        bit  act;
        x   = mPos % H_TOTAL;
        y   = mPos / H_TOTAL;
        act = (x < H_ACTIVE) && (y < V_ACTIVE);
        return mkObs(act && mDisp == 0, !(act && mDisp >= 0), act && mDisp == 1,
                     x, y, mFree[0], mFree[1], mFs, mUr);
    endfunction

    task automatic modelReset();
        mPos    = 0;
        mDisp   = -1;
        mPend[0] = 1'b0;
        mPend[1] = 1'b0;
        mFree[0] = 1'b0;
        mFree[1] = 1'b0;
        mFs     = 1'b0;
        mUr     = 1'b0;
    endtask

    // One clock edge of the reference model.
    task automatic modelStep(input bit en, input bit r0, input bit r1);
        bit rdy[2];
        int other;
        rdy[0]   = r0;
        rdy[1]   = r1;
        mFree[0] = 1'b0;
        mFree[1] = 1'b0;
        mFs      = 1'b0;
        mUr      = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (rdy[b] && mDisp != b) mPend[b] = 1'b1;
        end
        if (en) begin
            if (mPos == FRAME - 1) begin
                mPos = 0;
                mFs  = 1'b1;
                if (mDisp < 0) begin
                    if (mPend[0])      mDisp = 0;
                    else if (mPend[1]) mDisp = 1;
                    else               mUr   = 1'b1;
                end else begin
                    other = 1 - mDisp;
                    if (mPend[other]) begin
                        mPend[mDisp] = 1'b0;
                        mFree[mDisp] = 1'b1;
                        mDisp        = other;
                    end
                end
            end else begin
                mPos = mPos + 1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t got;
        got = {SelBuf0, SelBlank, SelBuf1, PixAddrX, PixAddrY,
               Buf0Free, Buf1Free, FrameStart, Underrun};
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s t=%0t: got sel(0/b/1)=%b%b%b x=%0d y=%0d free=%b%b fs=%b ur=%b, expected sel=%b%b%b x=%0d y=%0d free=%b%b fs=%b ur=%b",
                     name, $time,
                     got.sel0, got.blank, got.sel1, got.x, got.y,
                     got.free0, got.free1, got.fs, got.ur,
                     exp.sel0, exp.blank, exp.sel1, exp.x, exp.y,
                     exp.free0, exp.free1, exp.fs, exp.ur);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the same edge and
    // compare 1 time unit after the edge. Ready pulses last one cycle.
    task automatic applyStimulus(input bit en, input bit r0, input bit r1);
        Enable    = en;
        Buf0Ready = r0;
        Buf1Ready = r1;
        @(posedge Clk);
        modelStep(en, r0, r1);
        #1;
        checkOutput(phase, modelObs());
        Buf0Ready = 1'b0;
        Buf1Ready = 1'b0;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    // Reset is asserted between edges so its effect is seen without a clock.
    task automatic doReset();
        Enable    = 1'b0;
        Buf0Ready = 1'b0;
        Buf1Ready = 1'b0;
        Reset_n   = 1'b1;
        #1;
        Reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_async", mkObs(0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge Clk);
        #1;
        checkOutput("reset_held", mkObs(0, 1, 0, 0, 0, 0, 0, 0, 0));
        Reset_n = 1'b1;
    endtask

    task automatic addVec(input string name, input bit en, input bit r0,
                          input bit r1, input int cycles, input obs_t exp);
        tvec_t v;
        v.name   = name;
        v.en     = en;
        v.r0     = r0;
        v.r1     = r1;
        v.cycles = cycles;
        v.exp    = exp;
        tbl.push_back(v);
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        Reset_n      = 1'b1;
        Enable       = 1'b0;
        Buf0Ready    = 1'b0;
        Buf1Ready    = 1'b0;
        modelReset();

        // Directed table. Each row applies its inputs for the first cycle
        // (Ready inputs only there), then runs with no Ready for the rest.
        // The expected outputs apply after the row's last cycle.
        addVec("idle_line0",          1, 0, 0,  5, mkObs(0,1,0, 5,0, 0,0,0,0));
        addVec("idle_wrap_underrun",  1, 0, 0, 19, mkObs(0,1,0, 0,0, 0,0,1,1));
        addVec("buf0_ready_midframe", 1, 1, 0, 10, mkObs(0,1,0, 4,1, 0,0,0,0));
        addVec("show0_start",         1, 0, 0, 14, mkObs(1,0,0, 0,0, 0,0,1,0));
        addVec("show0_active",        1, 0, 0,  9, mkObs(1,0,0, 3,1, 0,0,0,0));
        addVec("show0_hblank",        1, 0, 0,  1, mkObs(0,1,0, 4,1, 0,0,0,0));
        addVec("show0_vblank",        1, 0, 0,  9, mkObs(0,1,0, 1,3, 0,0,0,0));
        addVec("buf0_ready_ignored",  1, 1, 0,  4, mkObs(0,1,0, 5,3, 0,0,0,0));
        addVec("show0_repeat",        1, 0, 0,  1, mkObs(1,0,0, 0,0, 0,0,1,0));
        addVec("buf1_ready",          1, 0, 1,  7, mkObs(1,0,0, 1,1, 0,0,0,0));
        addVec("swap_to_show1",       1, 0, 0, 17, mkObs(0,0,1, 0,0, 1,0,1,0));
        addVec("free_one_cycle",      1, 0, 0,  1, mkObs(0,0,1, 1,0, 0,0,0,0));
        addVec("enable_low_hold",     0, 0, 0,  3, mkObs(0,0,1, 1,0, 0,0,0,0));
        addVec("show1_repeat",        1, 0, 0, 23, mkObs(0,0,1, 0,0, 0,0,1,0));
        addVec("show1_end",           1, 0, 0, 23, mkObs(0,1,0, 5,3, 0,0,0,0));
        addVec("boundary_ready_swap", 1, 1, 0,  1, mkObs(1,0,0, 0,0, 0,1,1,0));

        $display("[TB] directed table, %0d rows", tbl.size());
        phase = "table_model";
        doReset();
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].cycles; c++) begin
                if (c == 0) applyStimulus(tbl[i].en, tbl[i].r0, tbl[i].r1);
                else        applyStimulus(tbl[i].en, 1'b0, 1'b0);
            end
            checkOutput(tbl[i].name, tbl[i].exp);
        end

        // Both Ready pulses together while idle: Buf0 shown first, then Buf1.
        $display("[TB] simultaneous ready sequence");
        phase = "both_ready_model";
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1);
        runIdle(FRAME - 1);
        checkOutput("both_ready_show0", mkObs(1,0,0, 0,0, 0,0,1,0));
        runIdle(FRAME);
        checkOutput("both_ready_swap",  mkObs(0,0,1, 0,0, 1,0,1,0));

        // Buf1Ready landing exactly on the boundary cycle while showing Buf0.
        $display("[TB] boundary-cycle ready sequence");
        phase = "boundary_ready_model";
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        runIdle(FRAME - 1);
        runIdle(FRAME - 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("boundary_buf1_swap", mkObs(0,0,1, 0,0, 1,0,1,0));

        // Ready for the displayed buffer is dropped: the frame just repeats.
        phase = "shown_ready_model";
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        runIdle(FRAME - 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runIdle(FRAME - 1);
        checkOutput("shown_ready_ignored", mkObs(1,0,0, 0,0, 0,0,1,0));

        // Alternating enable: six enabled cycles move the raster to (0,1).
        $display("[TB] alternating enable sequence");
        phase = "alt_enable_model";
        for (int i = 0; i < 12; i++) applyStimulus(i % 2 == 0, 1'b0, 1'b0);
        checkOutput("alternate_enable", mkObs(1,0,0, 0,1, 0,0,0,0));

        // Reset in the middle of a SHOW1 frame drops the pending buffer.
        $display("[TB] mid-frame reset sequence");
        phase = "midframe_reset_model";
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1);
        runIdle(FRAME - 1);
        runIdle(8);
        checkOutput("show1_before_reset", mkObs(0,0,1, 2,1, 0,0,0,0));
        doReset();
        runIdle(FRAME);
        checkOutput("post_reset_forgot", mkObs(0,1,0, 0,0, 0,0,1,1));
        applyStimulus(1'b1, 1'b0, 1'b1);
        runIdle(FRAME - 1);
        checkOutput("rearm_show1", mkObs(0,0,1, 0,0, 0,0,1,0));

        // Random traffic against the model, with one reset halfway through.
        $display("[TB] random phase");
        phase = "random_model";
        doReset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
